// File: rtl/adder_tree_feeder_if.sv
// rtl/adder_tree_feeder_if.sv - element stream in, packed adder_tree vector out
interface adder_tree_feeder_if #(
  parameter int DATAWIDTH  = 4,
  parameter int NUM_INPUTS = 16
);
  localparam int CNT_W = $clog2(NUM_INPUTS + 1);

  logic                            s_valid;
  logic                            s_ready;
  logic [DATAWIDTH-1:0]            s_data;
  logic                            s_last;
  logic                            flush;
  logic                            o_valid;
  logic [NUM_INPUTS*DATAWIDTH-1:0] o_data;
  logic [CNT_W-1:0]                o_count;
  logic                            o_partial;

  modport master (
    output s_valid, s_data, s_last, flush,
    input  s_ready, o_valid, o_data, o_count, o_partial
  );

  modport slave (
    input  s_valid, s_data, s_last, flush,
    output s_ready, o_valid, o_data, o_count, o_partial
  );
endinterface

// File: rtl/adder_tree_feeder.sv
// rtl/adder_tree_feeder.sv - packs serial elements into zero-padded adder_tree vectors
module adder_tree_feeder #(
  parameter int DATAWIDTH  = 4,
  parameter int NUM_INPUTS = 16
) (
  input  logic               clk,
  input  logic               rst,
  adder_tree_feeder_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam int VEC_W = NUM_INPUTS * DATAWIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_INPUTS);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [VEC_W-1:0]  buf_q, buf_d;
  logic [VEC_W-1:0]  merged;
  logic [CNT_W-1:0]  fill_count;
  logic              accept;
  logic              close;

  logic              s_ready_q;
  logic              o_valid_q;
  logic [VEC_W-1:0]  o_data_q;
  logic [CNT_W-1:0]  o_count_q;
  logic              o_partial_q;

  always_comb begin
    accept     = bus.s_valid & s_ready_q;
    merged     = buf_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (accept && (idx_q == CNT_W'(i))) begin
        merged[i*DATAWIDTH +: DATAWIDTH] = bus.s_data;
      end
    end
    fill_count = idx_q + CNT_W'(accept);
    // A bare flush only closes when something is buffered; in IDLE it needs an element.
    close      = (accept && ((idx_q == LAST_IDX) || bus.s_last)) ||
                 (bus.flush && ((state_q == FILL) || accept));

    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    if (close) begin
      state_d = IDLE;
      idx_d   = '0;
      buf_d   = '0;
    end else if (accept) begin
      state_d = FILL;
      idx_d   = fill_count;
      buf_d   = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      buf_q       <= '0;
      s_ready_q   <= 1'b0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_count_q   <= '0;
      o_partial_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      s_ready_q   <= 1'b1;
      o_valid_q   <= close;
      o_partial_q <= close && (fill_count < FULL_CNT);
      // Data and count hold between pulses; consumers qualify on o_valid.
      if (close) begin
        o_data_q  <= merged;
        o_count_q <= fill_count;
      end
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = o_data_q;
  assign bus.o_count   = o_count_q;
  assign bus.o_partial = o_partial_q;
endmodule
